// File: rtl/eBike_pkg.sv
// eBike_pkg: shared definitions for the eBike telemetry path.
//   - packet delimiters and length
//   - sequencer state encoding
//   - tlm_byte(): packet byte select by index
package eBike_pkg;

  localparam logic [7:0] TLM_DELIM1  = 8'hAA;
  localparam logic [7:0] TLM_DELIM2  = 8'h55;
  localparam int         TLM_PKT_LEN = 8;

  typedef enum logic [1:0] {TLM_IDLE, TLM_LOAD, TLM_XMIT} tlm_state_t;

  // Byte 'idx' of a packet built from one 12-bit snapshot triple.
  // High bytes carry only the top nibble, so their upper nibble is always 0.
  function automatic logic [7:0] tlm_byte(input logic [2:0]  idx,
                                          input logic [11:0] batt,
                                          input logic [11:0] curr,
                                          input logic [11:0] torq);
    logic [7:0] b;
    case (idx)
      3'd0:    b = TLM_DELIM1;
      3'd1:    b = TLM_DELIM2;
      3'd2:    b = {4'h0, batt[11:8]};
      3'd3:    b = batt[7:0];
      3'd4:    b = {4'h0, curr[11:8]};
      3'd5:    b = curr[7:0];
      3'd6:    b = {4'h0, torq[11:8]};
      default: b = torq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/UART_tx.sv
// UART_tx: 8N1 byte transmitter, LSB first.
//   clk, rst_n : clock, async active-low reset
//   trmt       : 1-clock pulse, loads tx_data and starts a frame
//   tx_data    : byte to send
//   TX         : registered serial output, idle high
//   tx_done    : 1-clock pulse during the last clock of the stop bit
module UART_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);

  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    sh_q, sh_d;     // bits still to go out: {stop, data}
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = busy_q && (baud_q == BW'(BAUD_DIV - 1));
  assign tx_done = bit_end && (bit_q == 4'd9);
  assign TX      = tx_q;

  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    tx_d   = tx_q;
    if (trmt) begin
      // start bit goes straight into the TX flop; the rest waits in sh
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = 4'd0;
      sh_d   = {1'b1, tx_data};
      tx_d   = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= 4'd0;
      sh_q   <= '1;
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
      tx_q   <= tx_d;
    end
  end

endmodule

// File: rtl/telemetry.sv
// telemetry: periodic UART telemetry packet transmitter.
//   Every 2^PERIOD_W clocks snapshots batt_v/avg_curr/avg_torque and sends
//   AA 55 {0,b_hi} b_lo {0,c_hi} c_lo {0,t_hi} t_lo over 8N1 UART.
//   clk, rst_n                    : clock, async active-low reset
//   batt_v, avg_curr, avg_torque  : 12-bit telemetry inputs
//   TX                            : UART serial output, idle high
module telemetry
  import eBike_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX
);

  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  tlm_state_t          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [11:0]         batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
  logic                trig, trmt, tx_done;
  logic [7:0]          tx_byte;

  assign trig    = &tmr_q;
  assign trmt    = (state_q == TLM_LOAD);
  assign tx_byte = tlm_byte(idx_q, batt_q, curr_q, torq_q);

  always_comb begin
    tmr_d   = tmr_q + PERIOD_W'(1);
    state_d = state_q;
    idx_d   = idx_q;
    batt_d  = batt_q;
    curr_d  = curr_q;
    torq_d  = torq_q;
    case (state_q)
      TLM_IDLE: if (trig) begin
        // all three captured together so a packet is self-consistent;
        // triggers outside IDLE are simply lost
        batt_d  = batt_v;
        curr_d  = avg_curr;
        torq_d  = avg_torque;
        state_d = TLM_LOAD;
      end
      TLM_LOAD: state_d = TLM_XMIT;
      TLM_XMIT: if (tx_done) begin
        if (idx_q == 3'(TLM_PKT_LEN - 1)) begin
          idx_d   = 3'd0;
          state_d = TLM_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = TLM_LOAD;
        end
      end
      default: state_d = TLM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      state_q <= TLM_IDLE;
      idx_q   <= 3'd0;
      batt_q  <= '0;
      curr_q  <= '0;
      torq_q  <= '0;
    end else begin
      tmr_q   <= tmr_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      batt_q  <= batt_d;
      curr_q  <= curr_d;
      torq_q  <= torq_d;
    end
  end

  UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_telemetry.sv
// tb_telemetry: two telemetry instances (period 2^12 and 2^10, 16 clk/bit)
// driven with shared inputs. A packet-level reference model predicts each
// byte and the clock it starts on; a UART receiver per instance decodes TX.
module tb_telemetry;

  localparam int BAUD      = 16;
  localparam int PW0       = 12;
  localparam int PW1       = 10;
  localparam int BYTE_CLKS = 10 * BAUD + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt_v = '0, avg_curr = '0, avg_torque = '0;
  logic [1:0]  tx;

  always #5 clk = ~clk;

  telemetry #(.PERIOD_W(PW0), .BAUD_DIV(BAUD)) dut0 (
    .clk(clk), .rst_n(rst_n), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .TX(tx[0]));

  telemetry #(.PERIOD_W(PW1), .BAUD_DIV(BAUD)) dut1 (
    .clk(clk), .rst_n(rst_n), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .TX(tx[1]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int per(input int d);
    return (d == 0) ? (1 << PW0) : (1 << PW1);
  endfunction

  typedef struct {
    logic [7:0] b;
    int         start;
    int         idx;
  } exp_t;

  exp_t        expq[2][$];
  int          edges;       // rising edges since reset release
  int          idle_n[2];   // first edge at which a trigger is accepted again
  logic [63:0] pkt;

  // Reference model: a trigger lands on every edge that is a multiple of the
  // period; it is honoured only if the previous packet has fully finished.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges <= 0;
      for (int d = 0; d < 2; d++) begin
        idle_n[d] <= 0;
        expq[d].delete();
      end
    end else begin
      edges <= edges + 1;
      for (int d = 0; d < 2; d++) begin
        if (((edges + 1) % per(d) == 0) && ((edges + 1) >= idle_n[d])) begin
          pkt = {8'hAA, 8'h55, 4'h0, batt_v[11:8], batt_v[7:0],
                 4'h0, avg_curr[11:8], avg_curr[7:0],
                 4'h0, avg_torque[11:8], avg_torque[7:0]};
          for (int i = 0; i < 8; i++)
            expq[d].push_back('{pkt[63-8*i -: 8], edges + 2 + i * BYTE_CLKS, i});
          idle_n[d] <= edges + 2 + 8 * BYTE_CLKS;
        end
      end
    end
  end

  // UART receivers, sampling mid-bit on the falling edge
  logic       mbusy[2];
  int         mcnt[2];
  int         mstart[2];
  logic [7:0] mbyte[2];
  int         last_pkt[2];
  int         rxn[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 1'b0; mcnt[d] = 0; mstart[d] = 0; mbyte[d] = '0;
      last_pkt[d] = -1; rxn[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mbusy[d]    <= 1'b0;
        last_pkt[d] <= -1;
      end else if (!mbusy[d]) begin
        if (expq[d].size() == 0) check($sformatf("idle_tx%0d", d), 32'(tx[d]), 32'd1);
        if (tx[d] === 1'b0) begin
          mbusy[d]  <= 1'b1;
          mcnt[d]   <= 1;
          mstart[d] <= edges;
        end
      end else begin
        mcnt[d] <= mcnt[d] + 1;
        if (mcnt[d] == 8) begin
          check($sformatf("start_bit%0d", d), 32'(tx[d]), 32'd0);
        end else if (mcnt[d] >= 24 && mcnt[d] <= 136 && (mcnt[d] % 16) == 8) begin
          mbyte[d] <= {tx[d], mbyte[d][7:1]};
        end else if (mcnt[d] == 152) begin
          mbusy[d] <= 1'b0;
          check($sformatf("stop_bit%0d", d), 32'(tx[d]), 32'd1);
          check($sformatf("rx_expected%0d", d), 32'(expq[d].size() > 0), 32'd1);
          if (expq[d].size() > 0) begin
            check($sformatf("rx_byte%0d_%0d", d, expq[d][0].idx), 32'(mbyte[d]), 32'(expq[d][0].b));
            check($sformatf("rx_start%0d_%0d", d, expq[d][0].idx), mstart[d], expq[d][0].start);
            if (expq[d][0].idx == 0) begin
              if (last_pkt[d] >= 0)
                check($sformatf("pkt_spacing%0d", d), mstart[d] - last_pkt[d],
                      (d == 0) ? (1 << PW0) : (2 << PW1));
              last_pkt[d] <= mstart[d];
            end
            void'(expq[d].pop_front());
            rxn[d] <= rxn[d] + 1;
          end
        end
      end
    end
  end

  task automatic wait_edge(input int target);
    int k = 0;
    while (edges < target && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("wait_edge", 32'(edges >= target), 32'd1);
  endtask

  initial begin
    batt_v = 12'hB80; avg_curr = 12'h3A5; avg_torque = 12'h700;
    repeat (3) @(negedge clk);
    check("rst_tx0", 32'(tx[0]), 32'd1);
    check("rst_tx1", 32'(tx[1]), 32'd1);
    rst_n = 1'b1;

    // byte 1 of the first dut0 packet is in flight here
    wait_edge((1 << PW0) + 250);
    batt_v = 12'h123;
    wait_edge(2 * (1 << PW0) + 1400);

    for (int r = 0; r < 4; r++) begin
      wait_edge((3 + r) * (1 << PW0) + int'($urandom_range(100, 4000)));
      batt_v     = 12'($urandom);
      avg_curr   = 12'($urandom);
      avg_torque = 12'($urandom);
    end

    wait_edge(7 * (1 << PW0) + 1400);
    batt_v = 12'hFFF; avg_curr = 12'hFFF; avg_torque = 12'hFFF;
    wait_edge(9 * (1 << PW0) + 1400);

    // reset while byte 4 of the tenth dut0 packet is on the wire
    wait_edge(10 * (1 << PW0) + 2 + 4 * BYTE_CLKS + 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx0", 32'(tx[0]), 32'd1);
    check("midrst_tx1", 32'(tx[1]), 32'd1);
    repeat (4) @(negedge clk);
    batt_v = 12'h456; avg_curr = 12'h089; avg_torque = 12'hABC;
    rst_n = 1'b1;
    wait_edge(2 * (1 << PW0) + 1400);

    // 9 full packets + bytes 0..3 of the aborted one + 2 after release
    check("rx_count0", rxn[0], 9 * 8 + 4 + 2 * 8);
    check("rx_pending0", expq[0].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/telemetry.md
Name: telemetry

Overview:
- Periodic UART telemetry transmitter inside eBike; drives the top-level TX pin.
- Every 2^PERIOD_W clocks it snapshots battery voltage, averaged motor current and averaged pedal torque.
- Sends them as one 8-byte framed packet over 8N1 UART to an off-board monitor. In simulation, the bench's UART_rcv is the consumer.
- Contains a packet sequencer and one UART byte transmitter.

Parameters:
- PERIOD_W, 20: width of the free-running packet-period timer. A packet starts every 2^PERIOD_W clocks (≈47.7 Hz at 50 MHz).
- BAUD_DIV, 2604: clocks per UART bit (19200 baud at 50 MHz). Must be ≥ 16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- batt_v  in  12  battery voltage from the A2D interface
- avg_curr  in  12  averaged motor current from the sensor conditioning block
- avg_torque  in  12  averaged pedal torque from the sensor conditioning block
- TX  out  1  UART serial output; idle high

Behaviour:
- Reset (async, rst_n low):
  - TX=1, period timer=0, sequencer in IDLE, byte index=0, snapshot registers=0.
  - Reset mid-packet aborts the packet immediately: TX high on the cycle rst_n falls.
- Period timer: PERIOD_W-bit up-counter, free-running, wraps. A trigger pulse occurs on the cycle the timer equals all-ones.
- Snapshot: on the trigger, if the sequencer is in IDLE:
  - Register batt_v, avg_curr and avg_torque together, so one packet is internally consistent.
  - Go to LOAD.
  - If the trigger arrives while not in IDLE, it is dropped, not queued.
- Packet byte order (index 0..7):
  - 0: 0xAA
  - 1: 0x55
  - 2: {4'h0, batt[11:8]}
  - 3: batt[7:0]
  - 4: {4'h0, curr[11:8]}
  - 5: curr[7:0]
  - 6: {4'h0, torque[11:8]}
  - 7: torque[7:0]
- Sequencer states:
  - IDLE: wait for trigger.
  - LOAD: select byte[index] and pulse trmt for 1 clock to the UART tx. Next state XMIT.
  - XMIT: wait for tx_done. Then:
    - if index==7: index=0, go to IDLE;
    - else: index+1, go to LOAD.
- Bytes are sent back-to-back. There is exactly 1 LOAD clock between the final stop bit of one byte and the start bit of the next. No extra idle bit-times.
- UART tx (8N1, LSB first):
  - On trmt, load the shift register {1'b1, byte, 1'b0}.
  - TX shows each bit for BAUD_DIV clocks: 10 bits, so 10×BAUD_DIV clocks.
  - tx_done pulses 1 clock at the end of the stop bit.
  - TX is registered and glitch-free.
- Latency: the start bit of byte 0 begins 2 clocks after the trigger cycle (LOAD, then UART load).
- Packet duration: 8×(10×BAUD_DIV+1) clocks. With defaults this is 208,328 clocks, much less than 2^20, so no trigger is ever dropped.
- Inputs changing during a packet do not affect the packet in flight.
- The upper nibble of payload high bytes is always 0.

Decomposition:
- Shared package eBike_pkg:
  - constants TLM_DELIM1=8'hAA, TLM_DELIM2=8'h55, TLM_PKT_LEN=8;
  - typedef enum logic[1:0] {TLM_IDLE, TLM_LOAD, TLM_XMIT} tlm_state_t.
- One sub-module: UART_tx (clk, rst_n, trmt, tx_data[7:0], TX, tx_done; parameter BAUD_DIV), instantiated once.
- The sequencer, timer and byte mux live in telemetry.

Test Plan:
- Reset check: hold rst_n=0, then release. Required: TX=1 continuously until the first trigger at clock 2^PERIOD_W−1 (run with PERIOD_W=12, BAUD_DIV=16 for speed).
- Nominal packet: batt_v=12'hB80, avg_curr=12'h3A5, avg_torque=12'h700.
  - Required: a UART_rcv monitor receives AA 55 0B 80 03 A5 07 00, in order.
  - Each byte has a stop bit of 1, and the bytes are 161 clocks apart (BAUD_DIV=16).
- Snapshot consistency: change batt_v to 12'h123 while byte 1 is in flight.
  - Required: the current packet still carries 0B 80.
  - The next packet carries 01 23.
- Dropped trigger: PERIOD_W=10, BAUD_DIV=16, so the packet (1288 clocks) exceeds the 1024-clock period.
  - Required: the trigger arriving mid-packet is ignored.
  - The next packet starts on the first trigger after returning to IDLE, i.e. packets start 2048 clocks apart.
- Reset mid-packet: assert rst_n low during byte 4.
  - Required: TX=1 within the same cycle.
  - After release, the next packet starts fresh with 0xAA at the next trigger.
- Full-scale values: all inputs 12'hFFF.
  - Required: bytes AA 55 0F FF 0F FF 0F FF.
  - Two consecutive packets are identical, with start bits exactly 2^PERIOD_W clocks apart.
